fft_stage_sequencer: RTL and testbench

//   Control FSM for the radix-2 DIT FFT core. Walks every stage and every butterfly

---
 rtl/fft_stage_sequencer_if.sv | 30 +++
 rtl/fft_stage_sequencer.sv | 136 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - control/handshake bundle between FFT controller, sequencer and butterfly unit
interface fft_stage_sequencer_if #(
    parameter int LOG2N = 5
);
    logic             start;
    logic             clear;
    logic             bf_done;
    logic             bf_start;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic [LOG2N-2:0] group_count;
    logic [2:0]       stage_count;
    logic             group_strobe;
    logic             stage_strobe;
    logic             busy;
    logic             fft_done;

    modport master (
        output start, clear, bf_done,
        input  bf_start, addr_a, addr_b, tw_idx, group_count, stage_count,
               group_strobe, stage_strobe, busy, fft_done
    );

    modport slave (
        input  start, clear, bf_done,
        output bf_start, addr_a, addr_b, tw_idx, group_count, stage_count,
               group_strobe, stage_strobe, busy, fft_done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - radix-2 DIT stage/group walker driving the shared butterfly unit
module fft_stage_sequencer #(
    parameter int LOG2N = 5
) (
    input  logic              clk,
    input  logic              rst,
    fft_stage_sequencer_if.slave bus
);
    localparam int AW = LOG2N;
    localparam int GW = LOG2N - 1;
    localparam logic [GW-1:0] G_LAST = '1;
    localparam logic [2:0]    S_LAST = 3'(LOG2N - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADV, DONE} state_t;

    state_t        state;
    logic [GW-1:0] group_q;
    logic [2:0]    stage_q;
    logic [AW-1:0] addr_a_q, addr_b_q;
    logic [GW-1:0] tw_q;
    logic          bf_start_q, group_strobe_q, stage_strobe_q, busy_q, fft_done_q;

    logic          last_group, last_stage;
    logic [GW-1:0] group_nx;
    logic [2:0]    stage_nx;
    logic [GW-1:0] sel_g;
    logic [2:0]    sel_s;
    logic [AW-1:0] a_nx, b_nx;
    logic [GW-1:0] tw_nx;

    // Upper leg: insert a zero bit at position s of the group number.
    function automatic logic [AW-1:0] calc_a(input logic [2:0] s, input logic [GW-1:0] g);
        logic [AW-1:0] gx, pos;
        gx  = {1'b0, g};
        pos = gx & ((AW'(1) << s) - AW'(1));
        return ((gx >> s) << (s + 3'd1)) | pos;
    endfunction

    function automatic logic [GW-1:0] calc_tw(input logic [2:0] s, input logic [GW-1:0] g);
        logic [GW-1:0] pos;
        pos = g & ((GW'(1) << s) - GW'(1));
        return pos << (4'(GW) - 4'(s));
    endfunction

    assign last_group = (group_q == G_LAST);
    assign last_stage = (stage_q == S_LAST);
    assign group_nx   = group_q + GW'(1);
    assign stage_nx   = last_group ? stage_q + 3'd1 : stage_q;

    // Addresses are loaded for the group about to be issued: (0,0) from IDLE, next group from ADV.
    always_comb begin
        sel_g = '0;
        sel_s = '0;
        if (state == ADV) begin
            sel_g = group_nx;
            sel_s = stage_nx;
        end
        a_nx  = calc_a(sel_s, sel_g);
        b_nx  = a_nx + (AW'(1) << sel_s);
        tw_nx = calc_tw(sel_s, sel_g);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state          <= IDLE;
            group_q        <= '0;
            stage_q        <= '0;
            addr_a_q       <= '0;
            addr_b_q       <= '0;
            tw_q           <= '0;
            bf_start_q     <= 1'b0;
            group_strobe_q <= 1'b0;
            stage_strobe_q <= 1'b0;
            busy_q         <= 1'b0;
            fft_done_q     <= 1'b0;
        end else begin
            bf_start_q     <= 1'b0;
            group_strobe_q <= 1'b0;
            stage_strobe_q <= 1'b0;
            fft_done_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= ISSUE;
                        bf_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        addr_a_q   <= a_nx;
                        addr_b_q   <= b_nx;
                        tw_q       <= tw_nx;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.bf_done) begin
                        state          <= ADV;
                        group_strobe_q <= 1'b1;
                        stage_strobe_q <= last_group;
                    end
                end
                ADV: begin
                    if (last_group && last_stage) begin
                        state      <= DONE;
                        fft_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        group_q    <= '0;
                        stage_q    <= '0;
                        addr_a_q   <= '0;
                        addr_b_q   <= '0;
                        tw_q       <= '0;
                    end else begin
                        state      <= ISSUE;
                        bf_start_q <= 1'b1;
                        group_q    <= group_nx;
                        stage_q    <= stage_nx;
                        addr_a_q   <= a_nx;
                        addr_b_q   <= b_nx;
                        tw_q       <= tw_nx;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bf_start     = bf_start_q;
    assign bus.addr_a       = addr_a_q;
    assign bus.addr_b       = addr_b_q;
    assign bus.tw_idx       = tw_q;
    assign bus.group_count  = group_q;
    assign bus.stage_count  = stage_q;
    assign bus.group_strobe = group_strobe_q;
    assign bus.stage_strobe = stage_strobe_q;
    assign bus.busy         = busy_q;
    assign bus.fft_done     = fft_done_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.LOG2N(5)) bus();
    fft_stage_sequencer #(.LOG2N(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int n_bfs = 0, n_gs = 0, n_ss = 0, n_fd = 0;

    int sp_s[4]  = '{0, 2, 4, 1};
    int sp_g[4]  = '{3, 5, 15, 0};
    int sp_a[4]  = '{6, 9, 15, 0};
    int sp_b[4]  = '{7, 13, 31, 2};
    int sp_tw[4] = '{0, 4, 15, 0};

    // Sampled on posedge: sees the value each output held during the cycle just ending.
    always @(posedge clk) begin
        if (bus.bf_start === 1'b1)     n_bfs++;
        if (bus.group_strobe === 1'b1) n_gs++;
        if (bus.stage_strobe === 1'b1) n_ss++;
        if (bus.fft_done === 1'b1)     n_fd++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_bf_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.bf_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bf_start_timeout", {31'b0, ok}, 1);
    endtask

    task automatic respond(input int already);
        repeat (3 - already) @(posedge clk);
        #1 bus.bf_done = 1'b1;
        @(posedge clk);
        #1 bus.bf_done = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_bf_start"}, bus.bf_start, 0);
        check({tag, "_fft_done"}, bus.fft_done, 0);
        check({tag, "_group"}, bus.group_count, 0);
        check({tag, "_stage"}, bus.stage_count, 0);
        check({tag, "_addr_a"}, bus.addr_a, 0);
        check({tag, "_addr_b"}, bus.addr_b, 0);
        check({tag, "_tw"}, bus.tw_idx, 0);
    endtask

    // kind: 0 plain pass, 1 start/bf_done injected in ISSUE, 2 clear in WAIT, 3 rst in WAIT
    task automatic run_pass(input int kind, input int at);
        int bfs0, gs0, ss0, fd0;
        bit ok;
        bfs0 = n_bfs; gs0 = n_gs; ss0 = n_ss; fd0 = n_fd;
        do_start();
        for (int i = 0; i < 80; i++) begin
            wait_bf_start(ok);
            if (!ok) return;
            check("seq_stage", bus.stage_count, i / 16);
            check("seq_group", bus.group_count, i % 16);
            check("busy_issue", bus.busy, 1);
            for (int k = 0; k < 4; k++) begin
                if (i == sp_s[k] * 16 + sp_g[k]) begin
                    check("spot_addr_a", bus.addr_a, sp_a[k]);
                    check("spot_addr_b", bus.addr_b, sp_b[k]);
                    check("spot_tw_idx", bus.tw_idx, sp_tw[k]);
                end
            end
            if (kind == 1 && i == at) begin
                bus.start = 1'b1;
                bus.bf_done = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
                bus.bf_done = 1'b0;
                @(negedge clk);
                check("t4_no_restart", bus.bf_start, 0);
                check("t4_no_gstrobe", bus.group_strobe, 0);
                check("t4_group", bus.group_count, i % 16);
                check("t4_stage", bus.stage_count, 2);
                check("t4_busy", bus.busy, 1);
                respond(1);
            end else if (kind == 2 && i == at) begin
                @(posedge clk);
                #1 bus.clear = 1'b1;
                @(posedge clk);
                #1 bus.clear = 1'b0;
                bus.bf_done = 1'b1;
                @(posedge clk);
                #1 bus.bf_done = 1'b0;
                repeat (3) @(negedge clk);
                check_idle("t5_idle");
                check("t5_bfs_count", n_bfs - bfs0, i + 1);
                check("t5_gs_count", n_gs - gs0, i);
                check("t5_ss_count", n_ss - ss0, 3);
                check("t5_fd_count", n_fd - fd0, 0);
                return;
            end else if (kind == 3 && i == at) begin
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                repeat (2) @(negedge clk);
                check_idle("t6_idle");
                check("t6_fd_count", n_fd - fd0, 0);
                return;
            end else begin
                respond(0);
            end
        end
        @(negedge clk);
        check("end_group_strobe", bus.group_strobe, 1);
        check("end_stage_strobe", bus.stage_strobe, 1);
        check("end_no_early_done", bus.fft_done, 0);
        @(negedge clk);
        check("end_fft_done", bus.fft_done, 1);
        check("end_busy_done", bus.busy, 0);
        @(negedge clk);
        check_idle("end_idle");
        check("pass_bf_start_count", n_bfs - bfs0, 80);
        check("pass_group_strobe_count", n_gs - gs0, 80);
        check("pass_stage_strobe_count", n_ss - ss0, 5);
        check("pass_fft_done_count", n_fd - fd0, 1);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.bf_done = 1'b0;

        // T1 reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_group_strobe", bus.group_strobe, 0);
        check("reset_stage_strobe", bus.stage_strobe, 0);

        // T2/T3/T4 full pass with disturbance at stage 2 group 0
        run_pass(1, 32);

        // T5 clear in WAIT at s3 g7, then a fresh full pass
        run_pass(2, 55);
        run_pass(0, 0);

        // T6 rst mid-run, then restart
        run_pass(3, 20);
        do_start();
        wait_bf_start(ok);
        if (ok) begin
            check("t6_stage", bus.stage_count, 0);
            check("t6_group", bus.group_count, 0);
            check("t6_addr_a", bus.addr_a, 0);
            check("t6_addr_b", bus.addr_b, 1);
            check("t6_tw", bus.tw_idx, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
